// File: rtl/square_motion_ctrl.sv
// square_motion_ctrl: steps a bouncing square once per N frames in vblank
// and renders the 12-bit RGB pixel one register stage after x/y.
module square_motion_ctrl #(
  parameter int          HD          = 640,
  parameter int          VD          = 480,
  parameter int          SQ_SIZE     = 64,
  parameter int          SPEED       = 1,
  parameter int          STEP_FRAMES = 1,
  parameter int          INIT_X      = 288,
  parameter int          INIT_Y      = 208,
  parameter logic        INIT_DX     = 1'b0,
  parameter logic        INIT_DY     = 1'b0,
  parameter logic [11:0] SQ_COLOR    = 12'hF00,
  parameter logic [11:0] BG_COLOR    = 12'h008
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        pause,
  output logic [11:0] rgb,
  output logic [9:0]  sq_x,
  output logic [9:0]  sq_y,
  output logic        frame_tick,
  output logic        busy,
  output logic        bounce_x,
  output logic        bounce_y
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC_X = 2'd1;
  localparam logic [1:0] S_CALC_Y = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam int DIV_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_FRAMES - 1);

  localparam logic [9:0]  X_MAX = 10'(HD - SQ_SIZE);
  localparam logic [9:0]  Y_MAX = 10'(VD - SQ_SIZE);
  localparam logic [10:0] SPD   = 11'(SPEED);
  localparam logic [10:0] SQS   = 11'(SQ_SIZE);

  logic [1:0]       state;
  logic [DIV_W-1:0] div;
  logic             dx;
  logic             dy;
  logic [9:0]       nx;
  logic [9:0]       ny;
  logic             ndx;
  logic             ndy;
  logic             flip_x;
  logic             flip_y;
  logic             frame_start;
  logic             advance;
  logic             trigger;
  logic [11:0]      ax;
  logic [11:0]      ay;
  logic             in_sq;

  // Packs {flip, new_dir, new_pos}; 11-bit math keeps edge tests wrap-free.
  function automatic logic [11:0] next_axis(
    input logic [9:0] pos,
    input logic       dir,
    input logic [9:0] lim
  );
    logic [10:0] p;
    logic [10:0] sum;
    logic [10:0] diff;
    logic [11:0] r;
    p    = {1'b0, pos};
    sum  = p + SPD;
    diff = p - SPD;
    if (!dir) begin
      if (sum >= {1'b0, lim}) r = {2'b11, lim};
      else                    r = {2'b00, sum[9:0]};
    end else begin
      if (p <= SPD) r = {2'b10, 10'd0};
      else          r = {2'b01, diff[9:0]};
    end
    return r;
  endfunction

  assign frame_start = (x == 10'd0) && (y == 10'(VD));
  assign advance     = frame_start && !pause && (state == S_IDLE);
  assign trigger     = advance && (div == DIV_LAST);
  assign busy        = (state != S_IDLE);

  // Candidate next position per axis from the committed position.
  always_comb begin
    ax = next_axis(sq_x, dx, X_MAX);
    ay = next_axis(sq_y, dy, Y_MAX);
  end

  // Frame divider and step sequencer; frames seen while busy are dropped.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      div   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (advance) begin
            div <= trigger ? '0 : div + DIV_W'(1);
            if (trigger) state <= S_CALC_X;
          end
        end
        S_CALC_X: state <= S_CALC_Y;
        S_CALC_Y: state <= S_COMMIT;
        S_COMMIT: state <= S_IDLE;
      endcase
    end
  end

  // Latch each axis result in its own calculation cycle.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      nx     <= '0;
      ndx    <= 1'b0;
      flip_x <= 1'b0;
      ny     <= '0;
      ndy    <= 1'b0;
      flip_y <= 1'b0;
    end else begin
      if (state == S_CALC_X) {flip_x, ndx, nx} <= ax;
      if (state == S_CALC_Y) {flip_y, ndy, ny} <= ay;
    end
  end

  // Commit position/direction leaving COMMIT and pulse bounce flags.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sq_x     <= 10'(INIT_X);
      sq_y     <= 10'(INIT_Y);
      dx       <= INIT_DX;
      dy       <= INIT_DY;
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
    end else begin
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      if (state == S_COMMIT) begin
        sq_x     <= nx;
        sq_y     <= ny;
        dx       <= ndx;
        dy       <= ndy;
        bounce_x <= flip_x;
        bounce_y <= flip_y;
      end
    end
  end

  // Frame pulse, independent of pause and of the sequencer.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) frame_tick <= 1'b0;
    else       frame_tick <= frame_start;
  end

  // Square hit test against the committed corner.
  always_comb begin
    in_sq = ({1'b0, x} >= {1'b0, sq_x}) &&
            ({1'b0, x} <  {1'b0, sq_x} + SQS) &&
            ({1'b0, y} >= {1'b0, sq_y}) &&
            ({1'b0, y} <  {1'b0, sq_y} + SQS);
  end

  // Registered pixel colour, aligned with registered syncs.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)          rgb <= '0;
    else if (!video_on) rgb <= '0;
    else if (in_sq)     rgb <= SQ_COLOR;
    else                rgb <= BG_COLOR;
  end

endmodule

// File: tb/tb_square_motion_ctrl.sv
// tb_square_motion_ctrl: four configurations driven with shared x/y,
// checked every cycle against a frame-level behavioural model.
module tb_square_motion_ctrl;

  localparam int PX[4]  = '{288, 574, 2, 288};
  localparam int PY[4]  = '{208, 208, 3, 208};
  localparam int PDX[4] = '{0, 0, 1, 0};
  localparam int PDY[4] = '{0, 0, 1, 0};
  localparam int PSP[4] = '{1, 4, 4, 1};
  localparam int PSF[4] = '{1, 1, 1, 3};

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic       video_on = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] x = 10'd100;
  logic [9:0] y = 10'd490;

  logic [11:0] rgb_o[4];
  logic [9:0]  sqx_o[4];
  logic [9:0]  sqy_o[4];
  logic        tick_o[4];
  logic        busy_o[4];
  logic        bx_o[4];
  logic        by_o[4];

  int total = 0;
  int bad = 0;

  int m_x[4], m_y[4], m_dx[4], m_dy[4], m_div[4], m_cnt[4];
  int p_x[4], p_y[4], p_dx[4], p_dy[4], p_fx[4], p_fy[4];
  int e_rgb[4], e_busy[4], e_bx[4], e_by[4];
  int e_tick;
  int sbx1, sbx2, sby2;

  always #5 clk_100MHz = ~clk_100MHz;

  square_motion_ctrl u0 (
    .clk_100MHz(clk_100MHz), .reset(reset), .video_on(video_on),
    .x(x), .y(y), .pause(pause), .rgb(rgb_o[0]),
    .sq_x(sqx_o[0]), .sq_y(sqy_o[0]), .frame_tick(tick_o[0]),
    .busy(busy_o[0]), .bounce_x(bx_o[0]), .bounce_y(by_o[0]));

  square_motion_ctrl #(.INIT_X(574), .SPEED(4)) u1 (
    .clk_100MHz(clk_100MHz), .reset(reset), .video_on(video_on),
    .x(x), .y(y), .pause(pause), .rgb(rgb_o[1]),
    .sq_x(sqx_o[1]), .sq_y(sqy_o[1]), .frame_tick(tick_o[1]),
    .busy(busy_o[1]), .bounce_x(bx_o[1]), .bounce_y(by_o[1]));

  square_motion_ctrl #(
    .INIT_X(2), .INIT_DX(1'b1), .INIT_Y(3), .INIT_DY(1'b1), .SPEED(4)
  ) u2 (
    .clk_100MHz(clk_100MHz), .reset(reset), .video_on(video_on),
    .x(x), .y(y), .pause(pause), .rgb(rgb_o[2]),
    .sq_x(sqx_o[2]), .sq_y(sqy_o[2]), .frame_tick(tick_o[2]),
    .busy(busy_o[2]), .bounce_x(bx_o[2]), .bounce_y(by_o[2]));

  square_motion_ctrl #(.STEP_FRAMES(3)) u3 (
    .clk_100MHz(clk_100MHz), .reset(reset), .video_on(video_on),
    .x(x), .y(y), .pause(pause), .rgb(rgb_o[3]),
    .sq_x(sqx_o[3]), .sq_y(sqy_o[3]), .frame_tick(tick_o[3]),
    .busy(busy_o[3]), .bounce_x(bx_o[3]), .bounce_y(by_o[3]));

  // One bounce-rule step on a single axis, lim = far edge limit.
  task automatic step(input int p, input int d, input int sp,
                      input int lim, output int np, output int nd,
                      output int fl);
    if (d == 0) begin
      if (p + sp >= lim) begin np = lim; nd = 1; fl = 1; end
      else begin np = p + sp; nd = 0; fl = 0; end
    end else begin
      if (p <= sp) begin np = 0; nd = 0; fl = 1; end
      else begin np = p - sp; nd = 1; fl = 0; end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_x[i] = PX[i]; m_y[i] = PY[i];
      m_dx[i] = PDX[i]; m_dy[i] = PDY[i];
      m_div[i] = 0; m_cnt[i] = 0;
      e_rgb[i] = 0; e_busy[i] = 0; e_bx[i] = 0; e_by[i] = 0;
    end
    e_tick = 0;
  endtask

  // Expected outputs after one rising edge, from the current inputs.
  task automatic model_edge();
    int fs;
    int ix, iy;
    if (reset) begin
      model_reset();
      return;
    end
    ix = int'(x);
    iy = int'(y);
    fs = (ix == 0 && iy == 480) ? 1 : 0;
    e_tick = fs;
    for (int i = 0; i < 4; i++) begin
      if (!video_on) e_rgb[i] = 0;
      else if (ix >= m_x[i] && ix < m_x[i] + 64 &&
               iy >= m_y[i] && iy < m_y[i] + 64) e_rgb[i] = 'hF00;
      else e_rgb[i] = 'h008;
      e_bx[i] = 0;
      e_by[i] = 0;
      if (m_cnt[i] == 3) begin
        m_x[i] = p_x[i]; m_y[i] = p_y[i];
        m_dx[i] = p_dx[i]; m_dy[i] = p_dy[i];
        e_bx[i] = p_fx[i]; e_by[i] = p_fy[i];
        m_cnt[i] = 0;
      end else if (m_cnt[i] > 0) begin
        m_cnt[i]++;
      end else if (fs == 1 && !pause) begin
        if (m_div[i] == PSF[i] - 1) begin
          m_div[i] = 0;
          step(m_x[i], m_dx[i], PSP[i], 576, p_x[i], p_dx[i], p_fx[i]);
          step(m_y[i], m_dy[i], PSP[i], 416, p_y[i], p_dy[i], p_fy[i]);
          m_cnt[i] = 1;
        end else begin
          m_div[i]++;
        end
      end
      e_busy[i] = (m_cnt[i] != 0) ? 1 : 0;
    end
  endtask

  task automatic chk(input string n, input int i, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[u%0d] got=%0h want=%0h t=%0t", n, i, act, exp,
               $time);
    end
  endtask

  task automatic lit(input string n, input int act, input int exp);
    chk(n, 9, act, exp);
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk("rgb", i, int'(rgb_o[i]), e_rgb[i]);
      chk("sq_x", i, int'(sqx_o[i]), m_x[i]);
      chk("sq_y", i, int'(sqy_o[i]), m_y[i]);
      chk("frame_tick", i, int'(tick_o[i]), e_tick);
      chk("busy", i, int'(busy_o[i]), e_busy[i]);
      chk("bounce_x", i, int'(bx_o[i]), e_bx[i]);
      chk("bounce_y", i, int'(by_o[i]), e_by[i]);
    end
  endtask

  task automatic cyc();
    @(posedge clk_100MHz);
    model_edge();
    @(negedge clk_100MHz);
    check_all();
  endtask

  task automatic idle_in();
    x = 10'd100;
    y = 10'd490;
    video_on = 1'b0;
  endtask

  // One compressed frame: a single frame_start cycle then blanking.
  task automatic frame(output int nb, output int nt);
    nb = 0;
    nt = 0;
    x = 10'd0;
    y = 10'd480;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 1) idle_in();
      if (busy_o[0]) nb++;
      if (tick_o[0]) nt++;
      if (k == 4) begin
        sbx1 = int'(bx_o[1]);
        sbx2 = int'(bx_o[2]);
        sby2 = int'(by_o[2]);
      end
    end
  endtask

  initial begin
    int nb, nt, bsum, tsum, r;
    model_reset();
    repeat (3) cyc();
    lit("rst_rgb", int'(rgb_o[0]), 0);
    lit("rst_sq_x", int'(sqx_o[0]), 288);
    lit("rst_sq_y", int'(sqy_o[0]), 208);
    lit("rst_busy", int'(busy_o[0]), 0);
    lit("rst_tick", int'(tick_o[0]), 0);
    reset = 1'b0;
    cyc();

    frame(nb, nt);
    lit("f1_busy_cycles", nb, 3);
    lit("f1_ticks", nt, 1);
    lit("f1_u0_x", int'(sqx_o[0]), 289);
    lit("f1_u0_y", int'(sqy_o[0]), 209);
    lit("f1_u1_x", int'(sqx_o[1]), 576);
    lit("f1_u1_bx", sbx1, 1);
    lit("f1_u2_x", int'(sqx_o[2]), 0);
    lit("f1_u2_y", int'(sqy_o[2]), 0);
    lit("f1_u2_bx", sbx2, 1);
    lit("f1_u2_by", sby2, 1);
    lit("f1_u3_x", int'(sqx_o[3]), 288);

    frame(nb, nt);
    lit("f2_u1_x", int'(sqx_o[1]), 572);
    lit("f2_u2_x", int'(sqx_o[2]), 4);
    lit("f2_u2_y", int'(sqy_o[2]), 4);
    lit("f2_u3_x", int'(sqx_o[3]), 288);

    x = 10'd288; y = 10'd208; video_on = 1'b1;
    cyc();
    lit("rnd_in", int'(rgb_o[3]), 'hF00);
    x = 10'd351;
    cyc();
    lit("rnd_right_in", int'(rgb_o[3]), 'hF00);
    x = 10'd352;
    cyc();
    lit("rnd_right_out", int'(rgb_o[3]), 'h008);
    x = 10'd288; y = 10'd272;
    cyc();
    lit("rnd_bottom_out", int'(rgb_o[3]), 'h008);
    y = 10'd208; video_on = 1'b0;
    cyc();
    lit("rnd_blank", int'(rgb_o[3]), 0);
    idle_in();

    frame(nb, nt);
    lit("f3_u3_x", int'(sqx_o[3]), 289);
    lit("f3_u3_y", int'(sqy_o[3]), 209);
    frame(nb, nt);
    lit("f4_u3_x", int'(sqx_o[3]), 289);
    lit("f4_u0_x", int'(sqx_o[0]), 292);

    pause = 1'b1;
    bsum = 0;
    tsum = 0;
    repeat (5) begin
      frame(nb, nt);
      bsum += nb;
      tsum += nt;
    end
    lit("pause_ticks", tsum, 5);
    lit("pause_busy", bsum, 0);
    lit("pause_u3_x", int'(sqx_o[3]), 289);
    lit("pause_u0_x", int'(sqx_o[0]), 292);
    pause = 1'b0;
    frame(nb, nt);
    lit("resume1_u3_x", int'(sqx_o[3]), 289);
    frame(nb, nt);
    lit("resume2_u3_x", int'(sqx_o[3]), 290);

    x = 10'd0; y = 10'd480;
    cyc();
    idle_in();
    cyc();
    lit("calcy_busy", int'(busy_o[0]), 1);
    reset = 1'b1;
    model_reset();
    #1;
    lit("arst_sq_x", int'(sqx_o[0]), 288);
    lit("arst_busy", int'(busy_o[0]), 0);
    repeat (2) cyc();
    reset = 1'b0;
    repeat (5) cyc();
    lit("arst_no_commit", int'(sqx_o[0]), 288);

    for (int n = 0; n < 20000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 12) begin
        x = 10'd0;
        y = 10'd480;
      end else begin
        x = 10'($urandom_range(0, 799));
        y = 10'($urandom_range(0, 524));
      end
      video_on = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) pause = ~pause;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 4999) == 0) begin
        reset = 1'b1;
        model_reset();
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
